// File: rtl/axis_power3_checker.sv
// AXI-Stream far-end checker for the power-of-3 sequence.
// Accepts NUM_BEATS beats per run, compares each one against the running
// power of three, and counts mismatches. It also captures the first bad beat
// and reports done/pass. tready can be throttled with a fixed stall pattern.
module axis_power3_checker #(
   parameter int DATA_SIZE    = 32,
   parameter int SEED         = 3,
   parameter int NUM_BEATS    = 16,
   parameter int STALL_PERIOD = 0,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                   s00_axis_aclk,
   input  logic                   s00_axis_aresetn,
   input  logic                   start,
   input  logic [DATA_SIZE-1:0]   s00_axis_tdata,
   input  logic [DATA_SIZE/8-1:0] s00_axis_tstrb,
   input  logic                   s00_axis_tvalid,
   input  logic                   s00_axis_tlast,
   output logic                   s00_axis_tready,
   output logic                   done,
   output logic                   pass,
   output logic [CNT_WIDTH-1:0]   beat_count,
   output logic [CNT_WIDTH-1:0]   error_count,
   output logic [CNT_WIDTH-1:0]   first_err_index,
   output logic [DATA_SIZE-1:0]   first_err_data,
   output logic [DATA_SIZE-1:0]   expected_data
);

   localparam bit                   STALL_EN = (STALL_PERIOD >= 2);
   localparam int                   SCW      = STALL_EN ? $clog2(STALL_PERIOD) : 1;
   localparam logic [SCW-1:0]       STALL_LAST = STALL_EN ? SCW'(STALL_PERIOD - 1) : '0;
   localparam logic [DATA_SIZE-1:0] SEED_V   = DATA_SIZE'(SEED);
   localparam logic [CNT_WIDTH-1:0] NB       = CNT_WIDTH'(NUM_BEATS);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state_q;
   logic [SCW-1:0]         stall_q, stall_d;
   logic [DATA_SIZE-1:0]   expected_q, expected_d;
   logic [CNT_WIDTH-1:0]   beat_q, beat_d;
   logic [CNT_WIDTH-1:0]   err_q, err_d;
   logic [CNT_WIDTH-1:0]   fei_q;
   logic [DATA_SIZE-1:0]   fed_q;
   logic                   done_q, pass_q;
   logic                   stall_hit, tready_w, accept, mismatch;

   // Strobes and tlast carry no information for this check.
   logic unused_sideband;
   assign unused_sideband = ^{s00_axis_tstrb, s00_axis_tlast};

   // tready is a pure decode of registered state, so there is no path from tvalid.
   assign stall_hit = STALL_EN && (stall_q == STALL_LAST);
   assign tready_w  = (state_q == RUN) && !stall_hit;
   assign accept    = s00_axis_tvalid && tready_w;
   assign mismatch  = (s00_axis_tdata != expected_q);

   // Next values for the per-beat datapath; the multiply by 3 is a shift-add
   // that wraps modulo 2^DATA_SIZE.
   always_comb begin
      stall_d    = (!STALL_EN || stall_hit) ? '0 : stall_q + 1'b1;
      expected_d = expected_q + (expected_q << 1);
      beat_d     = beat_q + 1'b1;
      err_d      = (mismatch && (err_q != '1)) ? err_q + 1'b1 : err_q;
   end

   // Run-control FSM; all status outputs are registered here.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         state_q    <= IDLE;
         stall_q    <= '0;
         expected_q <= SEED_V;
         beat_q     <= '0;
         err_q      <= '0;
         fei_q      <= '0;
         fed_q      <= '0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q    <= RUN;
                  stall_q    <= '0;
                  expected_q <= SEED_V;
                  beat_q     <= '0;
                  err_q      <= '0;
                  fei_q      <= '0;
                  fed_q      <= '0;
                  done_q     <= 1'b0;
                  pass_q     <= 1'b0;
               end
            end
            RUN: begin
               stall_q <= stall_d;
               if (accept) begin
                  beat_q     <= beat_d;
                  expected_q <= expected_d;
                  err_q      <= err_d;
                  // err_q never returns to zero within a run, so this fires once.
                  if (mismatch && (err_q == '0)) begin
                     fei_q <= beat_q;
                     fed_q <= s00_axis_tdata;
                  end
                  if (beat_d == NB) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     pass_q  <= (err_d == '0);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s00_axis_tready = tready_w;
   assign done            = done_q;
   assign pass            = pass_q;
   assign beat_count      = beat_q;
   assign error_count     = err_q;
   assign first_err_index = fei_q;
   assign first_err_data  = fed_q;
   assign expected_data   = expected_q;

endmodule

// File: tb/tb_axis_power3_checker.sv
// Directed bench for axis_power3_checker: three instances cover the default
// configuration, a stall pattern of 4, and a 25-beat run that wraps 2^32.
module tb_axis_power3_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start  [3];
   logic [31:0] tdata  [3];
   logic        tvalid [3];
   logic        tready [3];
   logic        done   [3];
   logic        pass   [3];
   logic [15:0] beat   [3];
   logic [15:0] errc   [3];
   logic [15:0] fei    [3];
   logic [31:0] fed    [3];
   logic [31:0] expd   [3];

   int total  = 0;
   int failed = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axis_power3_checker u_def (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .start(start[0]),
      .s00_axis_tdata(tdata[0]), .s00_axis_tstrb(4'hF), .s00_axis_tvalid(tvalid[0]),
      .s00_axis_tlast(1'b0), .s00_axis_tready(tready[0]), .done(done[0]), .pass(pass[0]),
      .beat_count(beat[0]), .error_count(errc[0]), .first_err_index(fei[0]),
      .first_err_data(fed[0]), .expected_data(expd[0]));

   axis_power3_checker #(.STALL_PERIOD(4)) u_bp (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .start(start[1]),
      .s00_axis_tdata(tdata[1]), .s00_axis_tstrb(4'hF), .s00_axis_tvalid(tvalid[1]),
      .s00_axis_tlast(1'b0), .s00_axis_tready(tready[1]), .done(done[1]), .pass(pass[1]),
      .beat_count(beat[1]), .error_count(errc[1]), .first_err_index(fei[1]),
      .first_err_data(fed[1]), .expected_data(expd[1]));

   axis_power3_checker #(.NUM_BEATS(25)) u_wr (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .start(start[2]),
      .s00_axis_tdata(tdata[2]), .s00_axis_tstrb(4'hF), .s00_axis_tvalid(tvalid[2]),
      .s00_axis_tlast(1'b0), .s00_axis_tready(tready[2]), .done(done[2]), .pass(pass[2]),
      .beat_count(beat[2]), .error_count(errc[2]), .first_err_index(fei[2]),
      .first_err_data(fed[2]), .expected_data(expd[2]));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called at a negedge; holds the beat until tready, returns at the negedge
   // after the accepting edge with tvalid still high.
   task automatic send(input int k, input logic [31:0] d, output int waits);
      waits = 0;
      tdata[k]  = d;
      tvalid[k] = 1'b1;
      while (!tready[k] && waits < 100) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 100) chk("send_timeout", 64'(waits), 64'd0);
      @(negedge clk);
   endtask

   task automatic go(input int k);
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
   endtask

   // Sends n powers of three starting at 3; beat bad_idx gets +1.
   task automatic run_stream(input int k, input int n, input int bad_idx, output int waits);
      logic [31:0] v;
      int w;
      v = 32'd3;
      waits = 0;
      for (int i = 0; i < n; i++) begin
         send(k, (i == bad_idx) ? v + 32'd1 : v, w);
         waits += w;
         v = v * 32'd3;
      end
      tvalid[k] = 1'b0;
   endtask

   initial begin
      int w, c0;
      logic [31:0] v;
      for (int k = 0; k < 3; k++) begin
         start[k] = 1'b0; tdata[k] = '0; tvalid[k] = 1'b0;
      end
      #12;
      chk("rst_tready", 64'(tready[0]), 64'd0);
      chk("rst_done",   64'(done[0]),   64'd0);
      chk("rst_beat",   64'(beat[0]),   64'd0);
      chk("rst_exp",    64'(expd[0]),   64'd3);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_tready", 64'(tready[0]), 64'd0);

      // basic run
      go(0);
      c0 = cyc;
      chk("run_tready", 64'(tready[0]), 64'd1);
      run_stream(0, 16, -1, w);
      chk("basic_cycles", 64'(cyc - c0), 64'd16);
      chk("basic_waits",  64'(w),        64'd0);
      chk("basic_done",   64'(done[0]),  64'd1);
      chk("basic_pass",   64'(pass[0]),  64'd1);
      chk("basic_err",    64'(errc[0]),  64'd0);
      chk("basic_beat",   64'(beat[0]),  64'd16);
      chk("basic_exp",    64'(expd[0]),  64'd129140163);
      chk("done_tready",  64'(tready[0]), 64'd0);
      @(negedge clk);
      chk("done_hold",    64'(done[0]),  64'd1);
      chk("beat_hold",    64'(beat[0]),  64'd16);

      // single corrupt beat at index 4
      go(0);
      run_stream(0, 16, 4, w);
      chk("bad_done", 64'(done[0]), 64'd1);
      chk("bad_pass", 64'(pass[0]), 64'd0);
      chk("bad_err",  64'(errc[0]), 64'd1);
      chk("bad_idx",  64'(fei[0]),  64'd4);
      chk("bad_data", 64'(fed[0]),  64'd244);

      // backpressure, one stall in four
      go(1);
      c0 = cyc;
      run_stream(1, 16, -1, w);
      chk("bp_cycles", 64'(cyc - c0), 64'd21);
      chk("bp_stalls", 64'(w),        64'd5);
      chk("bp_pass",   64'(pass[1]),  64'd1);
      chk("bp_beat",   64'(beat[1]),  64'd16);
      chk("bp_err",    64'(errc[1]),  64'd0);

      // 25 beats, crossing 2^32
      go(2);
      v = 32'd3;
      for (int i = 0; i < 25; i++) begin
         if (i == 20) chk("wrap_exp20", 64'(expd[2]), 64'd1870418611);
         send(2, v, w);
         v = v * 32'd3;
      end
      tvalid[2] = 1'b0;
      chk("wrap_done", 64'(done[2]), 64'd1);
      chk("wrap_pass", 64'(pass[2]), 64'd1);
      chk("wrap_beat", 64'(beat[2]), 64'd25);

      // tvalid gaps, then start held through DONE
      go(0);
      send(0, 32'd3, w);
      tvalid[0] = 1'b0;
      @(negedge clk);
      chk("gap_beat1", 64'(beat[0]), 64'd1);
      @(negedge clk);
      chk("gap_beat2", 64'(beat[0]), 64'd1);
      v = 32'd9;
      for (int i = 1; i < 16; i++) begin
         if (i == 15) start[0] = 1'b1;
         send(0, v, w);
         v = v * 32'd3;
      end
      tvalid[0] = 1'b0;
      chk("gap_done", 64'(done[0]), 64'd1);
      chk("gap_pass", 64'(pass[0]), 64'd1);
      @(negedge clk);
      start[0] = 1'b0;
      chk("rs_done",   64'(done[0]),   64'd0);
      chk("rs_beat",   64'(beat[0]),   64'd0);
      chk("rs_exp",    64'(expd[0]),   64'd3);
      chk("rs_tready", 64'(tready[0]), 64'd1);
      send(0, 32'd3, w);
      chk("rs_beat1",  64'(beat[0]),   64'd1);
      chk("rs_exp1",   64'(expd[0]),   64'd9);

      // async reset mid-run after 7 beats
      v = 32'd9;
      for (int i = 1; i < 7; i++) begin
         send(0, v, w);
         v = v * 32'd3;
      end
      chk("pre_rst_beat", 64'(beat[0]), 64'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_tready", 64'(tready[0]), 64'd0);
      chk("arst_beat",   64'(beat[0]),   64'd0);
      chk("arst_done",   64'(done[0]),   64'd0);
      chk("arst_exp",    64'(expd[0]),   64'd3);
      tvalid[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("post_rst_tready", 64'(tready[0]), 64'd0);
      chk("post_rst_beat",   64'(beat[0]),   64'd0);

      $display("%0d/%0d checks passed", total - failed, total);
      $finish;
   end

endmodule
